// File: rtl/qproc_pkg.sv
// Shared definitions for the qcore processor data-memory path.
package qproc_pkg;

  // Owner of an in-flight data-memory read.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DMA
  } dmem_own_t;

  // Default limit on consecutive cycles the DMA may lose arbitration.
  localparam int DMEM_MAX_WAIT_DEF = 4;

endpackage : qproc_pkg

// File: rtl/qcore_dmem_arb.sv
// Data-memory arbiter: CPU has fixed priority, DMA is protected from
// starvation by a wait counter, and one-cycle read data is routed back
// to whichever requester issued the read.
module qcore_dmem_arb
  import qproc_pkg::*;
#(
  parameter int DMEM_AW  = 8,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DMEM_MAX_WAIT_DEF
) (
  input  logic               c_clk_i,
  input  logic               c_rst_i,
  input  logic               core_req_i,
  input  logic               core_we_i,
  input  logic [DMEM_AW-1:0] core_addr_i,
  input  logic [DW-1:0]      core_w_dt_i,
  output logic               core_gnt_o,
  output logic               core_r_vld_o,
  output logic [DW-1:0]      core_r_dt_o,
  input  logic               dma_req_i,
  input  logic               dma_we_i,
  input  logic [DMEM_AW-1:0] dma_addr_i,
  input  logic [DW-1:0]      dma_w_dt_i,
  output logic               dma_gnt_o,
  output logic               dma_r_vld_o,
  output logic [DW-1:0]      dma_r_dt_o,
  output logic               mem_we_o,
  output logic [DMEM_AW-1:0] mem_addr_o,
  output logic [DW-1:0]      mem_w_dt_o,
  input  logic [DW-1:0]      mem_r_dt_i,
  output logic [15:0]        conflict_cnt_o
);

  localparam logic [3:0]  WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  logic [3:0]  wait_cnt_reg;
  logic [3:0]  wait_cnt_next;
  dmem_own_t   rd_own_reg;
  dmem_own_t   rd_own_next;
  logic [15:0] conflict_cnt_reg;
  logic [15:0] conflict_cnt_next;
  logic        force_dma;
  logic        core_gnt;
  logic        dma_gnt;

  // Grant decision: a DMA that has waited the limit wins, otherwise the CPU wins.
  always_comb begin
    force_dma = dma_req_i && (wait_cnt_reg == WAIT_LIMIT);
    core_gnt  = core_req_i && !force_dma;
    dma_gnt   = dma_req_i && !core_gnt;
  end

  // Memory port mux; with no grant the CPU inputs pass through harmlessly.
  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = core_addr_i;
    mem_w_dt_o = core_w_dt_i;
    if (dma_gnt) begin
      mem_we_o   = dma_we_i;
      mem_addr_o = dma_addr_i;
      mem_w_dt_o = dma_w_dt_i;
    end else if (core_gnt) begin
      mem_we_o   = core_we_i;
    end
  end

  // Next-state for the starvation counter, read owner tag and conflict counter.
  always_comb begin
    wait_cnt_next     = 4'd0;
    rd_own_next       = OWN_NONE;
    conflict_cnt_next = conflict_cnt_reg;

    if (dma_req_i && !dma_gnt && (wait_cnt_reg != WAIT_LIMIT)) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end else if (dma_req_i && !dma_gnt) begin
      wait_cnt_next = wait_cnt_reg;
    end

    if (core_gnt && !core_we_i) begin
      rd_own_next = OWN_CORE;
    end else if (dma_gnt && !dma_we_i) begin
      rd_own_next = OWN_DMA;
    end

    if (core_req_i && dma_req_i && (conflict_cnt_reg != CNT_MAX)) begin
      conflict_cnt_next = conflict_cnt_reg + 16'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      wait_cnt_reg     <= 4'd0;
      rd_own_reg       <= OWN_NONE;
      conflict_cnt_reg <= 16'd0;
    end else begin
      wait_cnt_reg     <= wait_cnt_next;
      rd_own_reg       <= rd_own_next;
      conflict_cnt_reg <= conflict_cnt_next;
    end
  end

  assign core_gnt_o     = core_gnt;
  assign dma_gnt_o      = dma_gnt;
  // A return pending across a reset cycle is suppressed, not just cleared after it.
  assign core_r_vld_o   = (rd_own_reg == OWN_CORE) && !c_rst_i;
  assign dma_r_vld_o    = (rd_own_reg == OWN_DMA) && !c_rst_i;
  assign core_r_dt_o    = mem_r_dt_i;
  assign dma_r_dt_o     = mem_r_dt_i;
  assign conflict_cnt_o = conflict_cnt_reg;

endmodule : qcore_dmem_arb

// File: tb/tb_qcore_dmem_arb.sv
// Self-checking bench for qcore_dmem_arb: directed vector table, starvation
// and reset sequences, randomized traffic against a behavioural model, and
// conflict-counter saturation.
module tb_qcore_dmem_arb;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk;
  logic          rst;
  logic          core_req, core_we, dma_req, dma_we;
  logic [AW-1:0] core_addr, dma_addr;
  logic [DW-1:0] core_wdt, dma_wdt;
  logic          core_gnt, core_vld, dma_gnt, dma_vld;
  logic [DW-1:0] core_rdt, dma_rdt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdt;
  logic [DW-1:0] mem_rdt;
  logic [15:0]   conf_cnt;

  int checks = 0;
  int errors = 0;

  qcore_dmem_arb #(.DMEM_AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .c_clk_i       (clk),
    .c_rst_i       (rst),
    .core_req_i    (core_req),
    .core_we_i     (core_we),
    .core_addr_i   (core_addr),
    .core_w_dt_i   (core_wdt),
    .core_gnt_o    (core_gnt),
    .core_r_vld_o  (core_vld),
    .core_r_dt_o   (core_rdt),
    .dma_req_i     (dma_req),
    .dma_we_i      (dma_we),
    .dma_addr_i    (dma_addr),
    .dma_w_dt_i    (dma_wdt),
    .dma_gnt_o     (dma_gnt),
    .dma_r_vld_o   (dma_vld),
    .dma_r_dt_o    (dma_rdt),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_w_dt_o    (mem_wdt),
    .mem_r_dt_i    (mem_rdt),
    .conflict_cnt_o(conf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents of the memory.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {4{a}} ^ 32'h5A5A0000;
  endfunction

  // One-port synchronous memory with a registered read.
  bit [DW-1:0] mem_val [256];
  bit          mem_wr  [256];
  always @(posedge clk) begin
    if (mem_we) begin
      mem_val[mem_addr] <= mem_wdt;
      mem_wr[mem_addr]  <= 1'b1;
    end
    mem_rdt <= mem_wr[mem_addr] ? mem_val[mem_addr] : pattern(mem_addr);
  end

  // ---------------- behavioural reference model ----------------
  bit [DW-1:0] shadow [256];
  int          streak;      // consecutive cycles DMA held its request and lost
  int          conflicts;   // cycles with both requests high, clamped
  int          pend_own;    // 0 none, 1 CPU, 2 DMA: read returning this cycle
  bit [DW-1:0] pend_data;
  bit          e_cg, e_dg;  // model grants for the current cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at mid-cycle with inputs stable: predict and compare all outputs.
  task automatic settle();
    #4;
    e_dg = dma_req && (streak >= MW || !core_req);
    e_cg = core_req && !e_dg;
    chk("core_gnt", core_gnt, e_cg);
    chk("dma_gnt", dma_gnt, e_dg);
    chk("mem_we", mem_we, (e_cg && core_we) || (e_dg && dma_we));
    if (e_cg) chk("mem_addr_c", mem_addr, core_addr);
    if (e_dg) chk("mem_addr_d", mem_addr, dma_addr);
    if (e_cg && core_we) chk("mem_wdt_c", mem_wdt, core_wdt);
    if (e_dg && dma_we) chk("mem_wdt_d", mem_wdt, dma_wdt);
    chk("core_r_vld", core_vld, (pend_own == 1) && !rst);
    chk("dma_r_vld", dma_vld, (pend_own == 2) && !rst);
    if (pend_own == 1 && !rst) chk("core_r_dt", core_rdt, pend_data);
    if (pend_own == 2 && !rst) chk("dma_r_dt", dma_rdt, pend_data);
    chk("conflict_cnt", {16'd0, conf_cnt}, conflicts[31:0]);
  endtask

  // Cross the clock edge and advance the model by one cycle.
  task automatic advance();
    @(posedge clk);
    #1;
    pend_own = 0;
    if (e_cg && !core_we) begin pend_own = 1; pend_data = shadow[core_addr]; end
    if (e_dg && !dma_we)  begin pend_own = 2; pend_data = shadow[dma_addr];  end
    if (e_cg && core_we) shadow[core_addr] = core_wdt;
    if (e_dg && dma_we)  shadow[dma_addr]  = dma_wdt;
    if (rst) begin
      streak = 0; conflicts = 0; pend_own = 0;
    end else begin
      streak = (dma_req && !e_dg) ? ((streak + 1 > MW) ? MW : streak + 1) : 0;
      if (core_req && dma_req && conflicts < 65535) conflicts++;
    end
  endtask

  task automatic drive(input bit r, input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [31:0] cd, input bit dr, input bit dw,
                       input logic [7:0] da, input logic [31:0] dd);
    rst = r; core_req = cr; core_we = cw; core_addr = ca; core_wdt = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdt = dd;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); advance();
    settle(); advance();
  endtask

  typedef struct {
    bit          r, cr, cw;
    logic [7:0]  ca;
    logic [31:0] cd;
    bit          dr, dw;
    logic [7:0]  da;
    logic [31:0] dd;
    bit          x_cg, x_dg, x_we, x_cv, x_dv;
    logic [31:0] x_rdt;
    logic [15:0] x_cc;
  } vec_t;

  vec_t vt [13];

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = pattern(8'(i));
    streak = 0; conflicts = 0; pend_own = 0; pend_data = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    streak = 0; conflicts = 0; pend_own = 0;

    //           r cr cw ca     cd            dr dw da     dd   cg dg we cv dv rdt            cc
    vt[0]  = '{0, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 32'h0,        16'd0};
    vt[1]  = '{0, 1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 0,   1, 0, 0, 0, 0, 32'h0,        16'd0};
    vt[2]  = '{0, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0,   0, 0, 0, 1, 0, 32'hDEADBEEF, 16'd0};
    vt[3]  = '{0, 1, 1, 8'h20, 32'h5,        0, 0, 8'h00, 0,   1, 0, 1, 0, 0, 32'h0,        16'd0};
    vt[4]  = '{0, 0, 0, 8'h00, 32'h0,        1, 0, 8'h20, 0,   0, 1, 0, 0, 0, 32'h0,        16'd0};
    vt[5]  = '{0, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0,   0, 0, 0, 0, 1, 32'h5,        16'd0};
    vt[6]  = '{0, 0, 0, 8'h00, 32'h0,        1, 0, 8'h30, 0,   0, 1, 0, 0, 0, 32'h0,        16'd0};
    vt[7]  = '{1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 32'h0,        16'd0};
    vt[8]  = '{0, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 32'h0,        16'd0};
    vt[9]  = '{0, 1, 0, 8'h11, 32'h0,        1, 0, 8'h12, 0,   1, 0, 0, 0, 0, 32'h0,        16'd0};
    vt[10] = '{0, 1, 1, 8'h40, 32'hA5,       1, 0, 8'h12, 0,   1, 0, 1, 1, 0, 32'h4B4B1111, 16'd1};
    vt[11] = '{0, 0, 0, 8'h00, 32'h0,        1, 0, 8'h12, 0,   0, 1, 0, 0, 0, 32'h0,        16'd2};
    vt[12] = '{0, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 0,   0, 0, 0, 0, 1, 32'h48481212, 16'd2};

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].r, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd,
            vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
      settle();
      chk("vec_core_gnt", core_gnt, vt[i].x_cg);
      chk("vec_dma_gnt", dma_gnt, vt[i].x_dg);
      chk("vec_mem_we", mem_we, vt[i].x_we);
      chk("vec_core_vld", core_vld, vt[i].x_cv);
      chk("vec_dma_vld", dma_vld, vt[i].x_dv);
      if (vt[i].x_cv) chk("vec_core_rdt", core_rdt, vt[i].x_rdt);
      if (vt[i].x_dv) chk("vec_dma_rdt", dma_rdt, vt[i].x_rdt);
      chk("vec_conflict", {16'd0, conf_cnt}, {16'd0, vt[i].x_cc});
      $display("vec %0d: cg=%b dg=%b we=%b cv=%b dv=%b rdt=%h cc=%0d",
               i, core_gnt, dma_gnt, mem_we, core_vld, dma_vld, mem_rdt, conf_cnt);
      advance();
    end

    // Starvation: both request every cycle; DMA wins on cycles 5 and 10.
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      drive(0, 1, 0, 8'(i), 0, 1, 0, 8'h80, 0);
      settle();
      if (i <= 10) begin
        chk("starve_core_gnt", core_gnt, (i % 5) != 0);
        chk("starve_dma_gnt", dma_gnt, (i % 5) == 0);
      end else begin
        chk("starve_conflict10", {16'd0, conf_cnt}, 32'd10);
      end
      $display("starve cycle %0d: cg=%b dg=%b cc=%0d", i, core_gnt, dma_gnt, conf_cnt);
      advance();
    end

    // DMA drops its request while waiting: CPU keeps priority afterwards.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 0, 8'(i), 0, (i != 4), 0, 8'h81, 0);
      settle();
      chk("drop_core_gnt", core_gnt, 1'b1);
      $display("drop cycle %0d: cg=%b dg=%b", i, core_gnt, dma_gnt);
      advance();
    end

    // Randomized traffic with the hold-until-granted handshake.
    do_reset();
    begin
      bit c_hold = 0, d_hold = 0;
      for (int n = 0; n < 3000; n++) begin
        bit r;
        r = ($urandom_range(0, 199) == 0);
        if (!c_hold) begin
          core_req  = ($urandom_range(0, 3) != 0);
          core_we   = $urandom_range(0, 1);
          core_addr = 8'($urandom_range(0, 15));
          core_wdt  = $urandom;
        end
        if (!d_hold || $urandom_range(0, 15) == 0) begin
          dma_req  = ($urandom_range(0, 2) != 0);
          dma_we   = $urandom_range(0, 1);
          dma_addr = 8'($urandom_range(0, 15));
          dma_wdt  = $urandom;
        end
        rst = r;
        settle();
        c_hold = core_req && !e_cg;
        d_hold = dma_req && !e_dg;
        advance();
      end
    end
    $display("random phase done: checks=%0d", checks);

    // Conflict counter saturation.
    do_reset();
    for (int k = 1; k <= 65538; k++) begin
      drive(0, 1, 0, 8'h05, 0, 1, 0, 8'h06, 0);
      settle();
      if (k == 65535) chk("sat_fffe", {16'd0, conf_cnt}, 32'h0000FFFE);
      if (k == 65536) chk("sat_ffff", {16'd0, conf_cnt}, 32'h0000FFFF);
      if (k == 65538) chk("sat_nowrap", {16'd0, conf_cnt}, 32'h0000FFFF);
      advance();
    end
    $display("saturation phase done: cc=%h", conf_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_qcore_dmem_arb
